// File: rtl/iobuf_turnaround_ctrl.sv
// iobuf_turnaround_ctrl
//   Shares one WIDTH-bit bank of half-duplex tri-state pad buffers between a
//   write requester and a read requester. On every direction change it inserts
//   TA_CYCLES cycles with the bus released. When both sides request at once,
//   grants alternate round-robin.
//
// Ports
//   C, R              clock (rising edge) and synchronous active-high reset
//   WR_REQ/WR_DATA    write request (held until WR_ACK); data latched on grant
//   WR_ACK            one-cycle pulse in the last driven cycle
//   RD_REQ            read request (held until RD_ACK)
//   RD_ACK/RD_DATA    one-cycle pulse; RD_DATA holds the last captured pad value
//   PAD_I/PAD_T/PAD_O connect straight to the IOBUF I/T/O pins (T=1 releases)
//   BUSY              high whenever the sequencer is not idle
module iobuf_turnaround_ctrl #(
    parameter int WIDTH         = 8,
    parameter int TA_CYCLES     = 2,
    parameter int DRIVE_CYCLES  = 1,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             WR_REQ,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             WR_ACK,
    input  logic             RD_REQ,
    output logic             RD_ACK,
    output logic [WIDTH-1:0] RD_DATA,
    output logic [WIDTH-1:0] PAD_I,
    output logic             PAD_T,
    input  logic [WIDTH-1:0] PAD_O,
    output logic             BUSY
);
    localparam int M1   = (TA_CYCLES > DRIVE_CYCLES) ? TA_CYCLES : DRIVE_CYCLES;
    localparam int MAXC = (M1 > SAMPLE_CYCLES) ? M1 : SAMPLE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

    typedef enum logic [1:0] {IDLE, TA, DRIVE, SAMPLE} state_t;
    typedef enum logic {DIR_READ = 1'b0, DIR_WRITE = 1'b1} dir_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;      // cycles remaining in the current phase after this one
    dir_t            dir, dir_n;      // direction of the transaction in flight
    dir_t            last_dir, last_dir_n;
    dir_t            rr_next, rr_next_n;
    dir_t            gdir;
    logic            start;
    logic [WIDTH-1:0] pad_i_n, rd_data_n;
    logic            pad_t_n, wr_ack_n, rd_ack_n;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dir_n      = dir;
        last_dir_n = last_dir;
        rr_next_n  = rr_next;
        pad_i_n    = PAD_I;
        rd_data_n  = RD_DATA;
        pad_t_n    = 1'b1;
        wr_ack_n   = 1'b0;
        rd_ack_n   = 1'b0;
        start      = 1'b0;
        gdir       = dir;

        case (state)
            IDLE: begin
                if (WR_REQ || RD_REQ) begin
                    if (WR_REQ && RD_REQ) gdir = rr_next;
                    else if (WR_REQ)      gdir = DIR_WRITE;
                    else                  gdir = DIR_READ;
                    rr_next_n = (gdir == DIR_WRITE) ? DIR_READ : DIR_WRITE;
                    dir_n     = gdir;
                    if (gdir == DIR_WRITE) pad_i_n = WR_DATA;
                    if (gdir != last_dir && TA_CYCLES > 0) begin
                        state_n = TA;
                        cnt_n   = CW'(TA_CYCLES - 1);
                    end else begin
                        start = 1'b1;
                    end
                end
            end
            TA: begin
                if (cnt == '0) start = 1'b1;
                else           cnt_n = cnt - CW'(1);
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_n    = IDLE;
                    last_dir_n = DIR_WRITE;
                end else begin
                    cnt_n    = cnt - CW'(1);
                    pad_t_n  = 1'b0;
                    wr_ack_n = (cnt == CW'(1));
                end
            end
            SAMPLE: begin
                if (cnt == '0) begin
                    state_n    = IDLE;
                    last_dir_n = DIR_READ;
                    rd_data_n  = PAD_O;
                    rd_ack_n   = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Entry into the data phase, either straight from a grant or at the end of TA.
        // Write ack is registered alongside PAD_T so it lands in the last driven cycle.
        if (start) begin
            if (gdir == DIR_WRITE) begin
                state_n  = DRIVE;
                cnt_n    = CW'(DRIVE_CYCLES - 1);
                pad_t_n  = 1'b0;
                wr_ack_n = (DRIVE_CYCLES == 1);
            end else begin
                state_n = SAMPLE;
                cnt_n   = CW'(SAMPLE_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            state    <= IDLE;
            cnt      <= '0;
            dir      <= DIR_READ;
            last_dir <= DIR_READ;
            rr_next  <= DIR_WRITE;
            PAD_I    <= '0;
            PAD_T    <= 1'b1;
            WR_ACK   <= 1'b0;
            RD_ACK   <= 1'b0;
            RD_DATA  <= '0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dir      <= dir_n;
            last_dir <= last_dir_n;
            rr_next  <= rr_next_n;
            PAD_I    <= pad_i_n;
            PAD_T    <= pad_t_n;
            WR_ACK   <= wr_ack_n;
            RD_ACK   <= rd_ack_n;
            RD_DATA  <= rd_data_n;
            BUSY     <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// Bench for iobuf_turnaround_ctrl. Three builds share one clock:
//   0: defaults (TA=2, DRIVE=1, SAMPLE=1)
//   1: TA=0, DRIVE=4, SAMPLE=2
//   2: TA=3, DRIVE=4, SAMPLE=2
// One build is active at a time. A timeline model computes, for every grant,
// the driven and busy cycles and the ack cycle, and pushes the expected ack
// into a queue. A monitor pops that queue on each ack and checks pad/busy
// state every cycle.
module tb_iobuf_turnaround_ctrl;
    localparam int NDUT = 3;

    typedef struct {
        bit         is_wr;
        int         ack_edge;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req  [NDUT];
    logic       rd_req  [NDUT];
    logic [7:0] wr_data [NDUT];
    logic       wr_ack  [NDUT];
    logic       rd_ack  [NDUT];
    logic       pad_t   [NDUT];
    logic       busy    [NDUT];
    logic [7:0] rd_data [NDUT];
    logic [7:0] pad_i   [NDUT];
    logic [7:0] pad_o = 8'h00;
    logic [7:0] exp_rd  [NDUT];

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  cur = 0;
    bit  mon_en = 1'b0;
    bit  rst_seen = 1'b0;
    bit  pad_fix_en = 1'b0;
    logic [7:0] pad_fix_val = 8'h00;

    ev_t        evq[$];
    bit         drv_mark[int];
    bit         busy_mark[int];
    logic [7:0] hist[int];

    // model state of the active build
    int m_ta, m_d, m_s, m_free;
    bit m_last, m_rr;   // 1 = write

    iobuf_turnaround_ctrl #(.WIDTH(8), .TA_CYCLES(2), .DRIVE_CYCLES(1), .SAMPLE_CYCLES(1)) dut0 (
        .C(clk), .R(rst), .WR_REQ(wr_req[0]), .WR_DATA(wr_data[0]), .WR_ACK(wr_ack[0]),
        .RD_REQ(rd_req[0]), .RD_ACK(rd_ack[0]), .RD_DATA(rd_data[0]), .PAD_I(pad_i[0]),
        .PAD_T(pad_t[0]), .PAD_O(pad_o), .BUSY(busy[0]));
    iobuf_turnaround_ctrl #(.WIDTH(8), .TA_CYCLES(0), .DRIVE_CYCLES(4), .SAMPLE_CYCLES(2)) dut1 (
        .C(clk), .R(rst), .WR_REQ(wr_req[1]), .WR_DATA(wr_data[1]), .WR_ACK(wr_ack[1]),
        .RD_REQ(rd_req[1]), .RD_ACK(rd_ack[1]), .RD_DATA(rd_data[1]), .PAD_I(pad_i[1]),
        .PAD_T(pad_t[1]), .PAD_O(pad_o), .BUSY(busy[1]));
    iobuf_turnaround_ctrl #(.WIDTH(8), .TA_CYCLES(3), .DRIVE_CYCLES(4), .SAMPLE_CYCLES(2)) dut2 (
        .C(clk), .R(rst), .WR_REQ(wr_req[2]), .WR_DATA(wr_data[2]), .WR_ACK(wr_ack[2]),
        .RD_REQ(rd_req[2]), .RD_ACK(rd_ack[2]), .RD_DATA(rd_data[2]), .PAD_I(pad_i[2]),
        .PAD_T(pad_t[2]), .PAD_O(pad_o), .BUSY(busy[2]));

    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d cyc=%0d actual=%0h expected=%0h", nm, cur, cyc, act, exp);
        end
    endtask

    // pad input driver; hist[e] is the value PAD_O holds at rising edge e
    initial forever begin
        @(negedge clk);
        pad_o = pad_fix_en ? pad_fix_val : 8'($urandom);
        hist[cyc + 1] = pad_o;
    end

    // monitor / scoreboard
    int  mk;
    ev_t mev;
    initial begin
        for (int i = 0; i < NDUT; i++) exp_rd[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_seen) for (int i = 0; i < NDUT; i++) exp_rd[i] = 8'h00;
            if (mon_en) begin
                mk = cur;
                if (drv_mark.exists(cyc) && evq.size() > 0 && evq[0].is_wr)
                    chk("pad_i_drive", 32'(pad_i[mk]), 32'(evq[0].data));
                while (evq.size() > 0 && evq[0].ack_edge < cyc) begin
                    chk("ack_by_cycle", cyc, evq[0].ack_edge);
                    void'(evq.pop_front());
                end
                if (wr_ack[mk] === 1'b1 || rd_ack[mk] === 1'b1) begin
                    if (evq.size() == 0) begin
                        chk("unexpected_ack", {30'd0, wr_ack[mk], rd_ack[mk]}, 0);
                    end else begin
                        mev = evq.pop_front();
                        chk("ack_kind", 32'(wr_ack[mk]), 32'(mev.is_wr));
                        chk("ack_cycle", cyc, mev.ack_edge);
                        if (mev.is_wr) chk("wr_pad_i", 32'(pad_i[mk]), 32'(mev.data));
                        else if (hist.exists(mev.ack_edge)) exp_rd[mk] = hist[mev.ack_edge];
                    end
                end
                chk("pad_t", 32'(pad_t[mk]), drv_mark.exists(cyc) ? 0 : 1);
                chk("busy", 32'(busy[mk]), busy_mark.exists(cyc) ? 1 : 0);
                chk("rd_data", 32'(rd_data[mk]), 32'(exp_rd[mk]));
            end
        end
    end

    // Timeline model: a grant at edge g occupies ta+len cycles; writes drive the
    // last len of them and ack in the final one; reads capture/ack one edge later.
    task automatic sched(input bit is_wr, input int g, input logic [7:0] data);
        int  ta, len;
        ev_t ev;
        ta  = (is_wr != m_last && m_ta > 0) ? m_ta : 0;
        len = is_wr ? m_d : m_s;
        for (int i = 0; i < ta + len; i++) busy_mark[g + i] = 1'b1;
        if (is_wr) for (int i = 0; i < m_d; i++) drv_mark[g + ta + i] = 1'b1;
        ev.is_wr    = is_wr;
        ev.ack_edge = is_wr ? g + ta + m_d - 1 : g + ta + m_s;
        ev.data     = data;
        evq.push_back(ev);
        m_free = ev.ack_edge + (is_wr ? 2 : 1);
        m_last = is_wr;
        m_rr   = !is_wr;
    endtask

    task automatic select(input int k);
        cur  = k;
        m_ta = (k == 0) ? 2 : (k == 1) ? 0 : 3;
        m_d  = (k == 0) ? 1 : 4;
        m_s  = (k == 0) ? 1 : 2;
        m_last = 1'b0;
        m_rr   = 1'b1;
        m_free = cyc + 1;
    endtask

    task automatic wait_free();
        @(negedge clk);
        while (cyc + 1 < m_free) @(negedge clk);
    endtask

    task automatic do_reset();
        wait_free();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b0;
        m_rr   = 1'b1;
        m_free = cyc + 1;
    endtask

    // kind: 0 write, 1 read, 2 both at once
    task automatic episode(input int kind, input bit drop_early, input logic [7:0] d);
        int e, g_wr, t;
        bit first;
        wait_free();
        e = cyc + 1;
        g_wr = -1;
        wr_data[cur] = d;
        wr_req[cur]  = (kind != 1);
        rd_req[cur]  = (kind != 0);
        if (kind == 2) begin
            first = m_rr;
            sched(first, e, d);
            if (first) g_wr = e;
            if (!first) g_wr = m_free;
            sched(!first, m_free, d);
        end else begin
            g_wr = (kind == 0) ? e : -1;
            sched(kind == 0, e, d);
        end
        t = 0;
        while ((wr_req[cur] || rd_req[cur]) && t < 200) begin
            @(negedge clk);
            t++;
            if (g_wr >= 0 && cyc >= g_wr) wr_data[cur] = 8'($urandom);
            if (drop_early && kind != 2 && cyc >= e) begin
                wr_req[cur] = 1'b0;
                rd_req[cur] = 1'b0;
            end
            if (wr_ack[cur]) wr_req[cur] = 1'b0;
            if (rd_ack[cur]) rd_req[cur] = 1'b0;
        end
        while (evq.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("episode_timeout", t, 0);
            wr_req[cur] = 1'b0;
            rd_req[cur] = 1'b0;
        end
    endtask

    // both requests held continuously: grants alternate starting at rr_next
    task automatic held_both(input int n);
        int t, nack;
        logic [7:0] d;
        wait_free();
        d = 8'($urandom);
        wr_data[cur] = d;
        wr_req[cur]  = 1'b1;
        rd_req[cur]  = 1'b1;
        for (int i = 0; i < n; i++) sched(m_rr, (i == 0) ? cyc + 1 : m_free, d);
        t = 0;
        nack = 0;
        while (nack < n && t < 300) begin
            @(negedge clk);
            t++;
            if (wr_ack[cur] || rd_ack[cur]) nack++;
        end
        wr_req[cur] = 1'b0;
        rd_req[cur] = 1'b0;
        if (t >= 300) chk("held_timeout", nack, n);
    endtask

    // reset lands in the 2nd DRIVE cycle: pads released, no ack
    task automatic reset_mid_write();
        int e, ta;
        wait_free();
        e  = cyc + 1;
        ta = m_last ? 0 : m_ta;
        wr_data[cur] = 8'($urandom);
        wr_req[cur]  = 1'b1;
        for (int i = 0; i < ta + 2; i++) busy_mark[e + i] = 1'b1;
        drv_mark[e + ta]     = 1'b1;
        drv_mark[e + ta + 1] = 1'b1;
        while (cyc < e + ta + 1) @(negedge clk);
        rst = 1'b1;
        wr_req[cur] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_pad_t", 32'(pad_t[cur]), 1);
        chk("abort_wr_ack", 32'(wr_ack[cur]), 0);
        m_last = 1'b0;
        m_rr   = 1'b1;
        m_free = cyc + 1;
    endtask

    task automatic random_eps(input int n);
        int kind;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 2);
            episode(kind, (kind != 2) && ($urandom_range(0, 3) == 0), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            wr_req[k]  = 1'b1;
            rd_req[k]  = 1'b0;
            wr_data[k] = 8'h5A;
        end
        // reset held two cycles with a write request pending
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                chk("rst_pad_t", 32'(pad_t[k]), 1);
                chk("rst_acks", {30'd0, wr_ack[k], rd_ack[k]}, 0);
                chk("rst_rd_data", 32'(rd_data[k]), 0);
                chk("rst_pad_i", 32'(pad_i[k]), 0);
                chk("rst_busy", 32'(busy[k]), 0);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) wr_req[k] = 1'b0;

        select(0);
        mon_en = 1'b1;
        episode(0, 1'b0, 8'hA5);
        pad_fix_val = 8'h3C;
        pad_fix_en  = 1'b1;
        episode(1, 1'b0, 8'h00);
        chk("read_3c", 32'(rd_data[0]), 32'h3C);
        pad_fix_en = 1'b0;
        episode(0, 1'b0, 8'h96);
        episode(0, 1'b0, 8'h69);
        random_eps(25);
        do_reset();
        held_both(5);

        select(1);
        held_both(4);
        random_eps(30);

        select(2);
        reset_mid_write();
        episode(1, 1'b0, 8'h00);
        episode(0, 1'b0, 8'hC3);
        random_eps(20);

        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule
